// File: rtl/sort_result_serializer.sv
// Serializes a 4-word sort result onto a valid/ready stream, one word per accepted beat.
// Each captured frame is checked against the expected order, and order_err reports the result.
module sort_result_serializer #(
    parameter int WIDTH     = 4,
    parameter bit ASCENDING = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             order_err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [WIDTH-1:0] frame_buf [4];
    logic             unordered;

    // Equal neighbours are legal in either direction.
    always_comb begin
        unordered = 1'b0;
        if (ASCENDING) begin
            unordered = (d1 > d2) || (d2 > d3) || (d3 > d4);
        end else begin
            unordered = (d1 < d2) || (d2 < d3) || (d3 < d4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            order_err <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                frame_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        frame_buf[0] <= d1;
                        frame_buf[1] <= d2;
                        frame_buf[2] <= d3;
                        frame_buf[3] <= d4;
                        order_err    <= unordered;
                        idx          <= '0;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == 2'd3) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign load_ready = (state == IDLE);
    assign busy       = (state == SEND);
    assign out_valid  = (state == SEND);
    assign out_last   = (state == SEND) && (idx == 2'd3);
    assign out_data   = (state == SEND) ? frame_buf[idx] : '0;

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed bench for sort_result_serializer: streaming, stalls, order check, load blocking, reset.
module tb_sort_result_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid, load_valid_d;
    logic [3:0] d1, d2, d3, d4;
    logic       out_ready;

    logic       load_ready, out_valid, out_last, busy, order_err;
    logic [3:0] out_data;
    logic       load_ready_d, out_valid_d, out_last_d, busy_d, order_err_d;
    logic [3:0] out_data_d;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sort_result_serializer #(.WIDTH(4), .ASCENDING(1'b1)) u_asc (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .order_err(order_err)
    );

    sort_result_serializer #(.WIDTH(4), .ASCENDING(1'b0)) u_desc (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid_d), .load_ready(load_ready_d),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .out_data(out_data_d), .out_valid(out_valid_d), .out_ready(out_ready),
        .out_last(out_last_d), .busy(busy_d), .order_err(order_err_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // Advance one edge and settle; all driving and sampling happens 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [15:0] f);
        {d1, d2, d3, d4} = f;
    endtask

    // Present a frame for one capture edge on the ascending instance.
    task automatic load(input logic [15:0] f);
        set_words(f);
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    // Accept four beats with out_ready high, checking words and last flag.
    task automatic drain(input string tag, input logic [15:0] f);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, out_valid, 1'b1);
            check({tag, "_data"}, out_data, f[15 - 4*i -: 4]);
            check({tag, "_last"}, out_last, (i == 3));
            check({tag, "_lrdy"}, load_ready, 1'b0);
            tick();
        end
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_valid_end"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [3:0]  exp_w [4];
        logic [6:0]  pat;
        int          k;

        rst_n = 1'b0; load_valid = 1'b0; load_valid_d = 1'b0;
        out_ready = 1'b0; set_words(16'h0000);
        #12;
        check("rst_lrdy", load_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 4'd0);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", order_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: straight stream
        out_ready = 1'b1;
        load(16'h1246);
        check("t1_err", order_err, 1'b0);
        check("t1_busy", busy, 1'b1);
        drain("t1", 16'h1246);

        // 2: stall pattern 1,0,0,1,1,0,1 (applied to edges in time order)
        exp_w = '{4'd1, 4'd2, 4'd4, 4'd6};
        pat = 7'b1011001;
        load(16'h1246);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            check("t2_valid", out_valid, 1'b1);
            check("t2_data", out_data, exp_w[k]);
            check("t2_last", out_last, (k == 3));
            if (pat[i]) k++;
            tick();
        end
        check("t2_beats", k, 4);
        check("t2_busy_end", busy, 1'b0);

        // 3: unsorted frame still streams; next sorted frame clears the flag
        load(16'h6241);
        check("t3_err_set", order_err, 1'b1);
        drain("t3a", 16'h6241);
        check("t3_err_held", order_err, 1'b1);
        load(16'h3333);
        check("t3_err_clr", order_err, 1'b0);
        drain("t3b", 16'h3333);

        // 4: descending instance
        set_words(16'h6421);
        load_valid_d = 1'b1;
        tick();
        load_valid_d = 1'b0;
        check("t4_err_desc_ok", order_err_d, 1'b0);
        check("t4_d_first", out_data_d, 4'd6);
        for (int i = 0; i < 4; i++) tick();
        check("t4_d_idle", busy_d, 1'b0);
        set_words(16'h1246);
        load_valid_d = 1'b1;
        tick();
        load_valid_d = 1'b0;
        check("t4_err_desc_bad", order_err_d, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("t4_d_idle2", busy_d, 1'b0);

        // 5: load_valid held during SEND is ignored until IDLE
        load(16'h1246);
        set_words(16'h9999);
        load_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_lrdy", load_ready, 1'b0);
            check("t5_data", out_data, exp_w[i]);
            tick();
        end
        check("t5_idle_lrdy", load_ready, 1'b1);
        check("t5_idle_valid", out_valid, 1'b0);
        tick();
        load_valid = 1'b0;
        drain("t5b", 16'h9999);

        // 6: async reset mid-frame
        load(16'h1246);
        tick();
        tick();
        check("t6_pre_data", out_data, 4'd4);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_data", out_data, 4'd0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_last", out_last, 1'b0);
        check("t6_rst_err", order_err, 1'b0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_post_lrdy", load_ready, 1'b1);
            check("t6_post_valid", out_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
